// File: rtl/dice_cfg_pkg.sv
// Shared widths, loader state encoding and tile config type for the dice tile config loader.
package dice_cfg_pkg;

    localparam int TILE_CFG_W     = 156;
    localparam int CFG_WORD_W     = 32;
    localparam int WORDS_PER_TILE = (TILE_CFG_W + CFG_WORD_W - 1) / CFG_WORD_W;
    localparam int WORD_IDX_W     = $clog2(WORDS_PER_TILE);
    // Bits of the final word of a tile that land in the shadow; the rest are dropped.
    localparam int LAST_W_BITS    = TILE_CFG_W - CFG_WORD_W * (WORDS_PER_TILE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loader_state_e;

    typedef logic [TILE_CFG_W-1:0] tile_cfg_t;

endpackage

// File: rtl/dice_tile_cfg_loader_if.sv
// Config stream and status bundle between a config source (master) and the loader (slave).
// Parity signals exist only when DICE_CFG_PARITY_EN is defined.
interface dice_tile_cfg_loader_if
    import dice_cfg_pkg::*;
#(
    parameter int NUM_TILES = 4
) ();

    logic                            cfg_start;
    logic                            cfg_abort;
    logic                            cfg_valid;
    logic [CFG_WORD_W-1:0]           cfg_data;
    logic                            cfg_ready;
    logic                            cfg_busy;
    logic                            cfg_done;
    logic [NUM_TILES*TILE_CFG_W-1:0] tile_cfg;
`ifdef DICE_CFG_PARITY_EN
    logic                            cfg_parity;
    logic                            cfg_err;

    modport master (
        output cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_parity,
        input  cfg_ready, cfg_busy, cfg_done, tile_cfg, cfg_err
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_valid, cfg_data, cfg_parity,
        output cfg_ready, cfg_busy, cfg_done, tile_cfg, cfg_err
    );
`else
    modport master (
        output cfg_start, cfg_abort, cfg_valid, cfg_data,
        input  cfg_ready, cfg_busy, cfg_done, tile_cfg
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_valid, cfg_data,
        output cfg_ready, cfg_busy, cfg_done, tile_cfg
    );
`endif

endinterface

// File: rtl/dice_tile_cfg_loader_shadow_bank.sv
// Per-tile shadow registers with word-write decode and an atomic parallel copy to the active outputs.
module dice_cfg_shadow_bank
    import dice_cfg_pkg::*;
#(
    parameter int NUM_TILES  = 4,
    parameter int TILE_IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_wr_en,
    input  logic [TILE_IDX_W-1:0]           i_tile_idx,
    input  logic [WORD_IDX_W-1:0]           i_word_idx,
    input  logic [CFG_WORD_W-1:0]           i_wr_data,
    input  logic                            i_commit,
    output logic [NUM_TILES*TILE_CFG_W-1:0] o_tile_cfg
);

    tile_cfg_t                       r_shadow [NUM_TILES];
    logic [NUM_TILES*TILE_CFG_W-1:0] r_active;
    logic                            w_unused_hi;

    // Upper bits of the last word of each tile have no home in the shadow.
    assign w_unused_hi = ^i_wr_data[CFG_WORD_W-1:LAST_W_BITS];
    assign o_tile_cfg  = r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_TILES; t++) begin
                r_shadow[t] <= '0;
            end
            r_active <= '0;
        end else begin
            if (i_wr_en) begin
                for (int unsigned t = 0; t < NUM_TILES; t++) begin
                    if (i_tile_idx == TILE_IDX_W'(t)) begin
                        for (int unsigned w = 0; w < WORDS_PER_TILE - 1; w++) begin
                            if (i_word_idx == WORD_IDX_W'(w)) begin
                                r_shadow[t][w*CFG_WORD_W +: CFG_WORD_W] <= i_wr_data;
                            end
                        end
                        if (i_word_idx == WORD_IDX_W'(WORDS_PER_TILE - 1)) begin
                            r_shadow[t][TILE_CFG_W-1 -: LAST_W_BITS] <= i_wr_data[LAST_W_BITS-1:0];
                        end
                    end
                end
            end
            if (i_commit) begin
                for (int unsigned t = 0; t < NUM_TILES; t++) begin
                    r_active[t*TILE_CFG_W +: TILE_CFG_W] <= r_shadow[t];
                end
            end
        end
    end

endmodule

// File: rtl/dice_tile_cfg_loader.sv
// Streams 32-bit config words into per-tile shadows and commits a full frame atomically to tile_cfg.
// Optional word parity checking is enabled by defining DICE_CFG_PARITY_EN.
module dice_tile_cfg_loader
    import dice_cfg_pkg::*;
#(
    parameter int NUM_TILES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dice_tile_cfg_loader_if.slave   cfg
);

    localparam int TILE_IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    loader_state_e           r_state;
    logic [TILE_IDX_W-1:0]   r_tile_cnt;
    logic [WORD_IDX_W-1:0]   r_word_cnt;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_par_err;
    logic                    w_abort;
    logic                    w_write;
    logic                    w_word_last;
    logic                    w_tile_last;

    assign w_accept = cfg.cfg_valid && (r_state == LOAD);

`ifdef DICE_CFG_PARITY_EN
    logic r_err;

    assign w_par_err   = w_accept && ((^cfg.cfg_data) != cfg.cfg_parity);
    assign cfg.cfg_err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && cfg.cfg_start) begin
            r_err <= 1'b0;
        end else if (w_par_err) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_par_err = 1'b0;
`endif

    // Abort (or a bad-parity word) takes priority over the word handshaked in the same cycle.
    assign w_abort     = (r_state == LOAD) && (cfg.cfg_abort || w_par_err);
    assign w_write     = w_accept && !w_abort;
    assign w_word_last = (r_word_cnt == WORD_IDX_W'(WORDS_PER_TILE - 1));
    assign w_tile_last = (r_tile_cnt == TILE_IDX_W'(NUM_TILES - 1));

    assign cfg.cfg_ready = (r_state == LOAD);
    assign cfg.cfg_busy  = (r_state != IDLE);
    assign cfg.cfg_done  = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tile_cnt <= '0;
            r_word_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg.cfg_start) begin
                        r_state    <= LOAD;
                        r_tile_cnt <= '0;
                        r_word_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (w_write) begin
                        if (w_word_last) begin
                            r_word_cnt <= '0;
                            r_tile_cnt <= r_tile_cnt + 1'b1;
                            if (w_tile_last) begin
                                r_state <= COMMIT;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dice_cfg_shadow_bank #(
        .NUM_TILES  (NUM_TILES),
        .TILE_IDX_W (TILE_IDX_W)
    ) u_shadow_bank (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_write),
        .i_tile_idx (r_tile_cnt),
        .i_word_idx (r_word_cnt),
        .i_wr_data  (cfg.cfg_data),
        .i_commit   (r_state == COMMIT),
        .o_tile_cfg (cfg.tile_cfg)
    );

endmodule

// File: tb/tb_dice_tile_cfg_loader.sv
// Directed self-checking bench for dice_tile_cfg_loader: load, gaps, abort, start pulses, reset, parity.
module tb_dice_tile_cfg_loader;
    import dice_cfg_pkg::*;

    localparam int NT     = 4;
    localparam int FULL_W = NT * TILE_CFG_W;
    localparam int NWORDS = NT * WORDS_PER_TILE;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   n_done;
    bit   in_load;

    dice_tile_cfg_loader_if #(.NUM_TILES(NT)) cfg_if ();

    dice_tile_cfg_loader #(.NUM_TILES(NT)) dut (
        .clk (clk),
        .rst (rst),
        .cfg (cfg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // cfg_ready must track exactly the cycles the bench believes the loader is in LOAD.
    always @(negedge clk) begin
        if (!rst) begin
            n_assert++;
            assert (cfg_if.cfg_ready === in_load) else begin
                n_fail++;
                $error("FAIL ready_vs_load observed=%b expected=%b", cfg_if.cfg_ready, in_load);
            end
        end
        if (cfg_if.cfg_done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [FULL_W-1:0] obs, input logic [FULL_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FULL_W-1:0] frame_img(input logic [31:0] base);
        logic [FULL_W-1:0] v;
        logic [31:0]       wd;
        v = '0;
        for (int t = 0; t < NT; t++) begin
            for (int w = 0; w < WORDS_PER_TILE; w++) begin
                wd = base + 32'(t * WORDS_PER_TILE + w);
                if (w < WORDS_PER_TILE - 1) v[t*TILE_CFG_W + 32*w +: 32] = wd;
                else                        v[t*TILE_CFG_W + 128 +: 28] = wd[27:0];
            end
        end
        return v;
    endfunction

    task automatic send_word(input logic [31:0] d, input bit bad_par, input int gap_pct);
        int unsigned budget;
        int          gaps;
        gaps = 0;
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct && gaps < 8) begin
            cfg_if.cfg_valid = 1'b0;
            @(posedge clk); #1;
            gaps++;
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
`ifdef DICE_CFG_PARITY_EN
        cfg_if.cfg_parity = (^d) ^ bad_par;
`endif
        budget = 0;
        while (cfg_if.cfg_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_timeout observed=ready_low expected=ready_high");
        end
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic start_frame();
        cfg_if.cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_if.cfg_start = 1'b0;
        in_load = 1'b1;
    endtask

    task automatic run_frame(input logic [31:0] base, input int gap_pct, input string tag);
        int d0;
        d0 = n_done;
        start_frame();
        for (int k = 0; k < NWORDS; k++) send_word(base + 32'(k), 1'b0, gap_pct);
        in_load = 1'b0;
        check({tag, "_commit_busy"}, FULL_W'(cfg_if.cfg_busy), FULL_W'(1));
        check({tag, "_commit_nodone"}, FULL_W'(cfg_if.cfg_done), FULL_W'(0));
        @(posedge clk); #1;
        check({tag, "_done"}, FULL_W'(cfg_if.cfg_done), FULL_W'(1));
        check({tag, "_tile_cfg"}, cfg_if.tile_cfg, frame_img(base));
        check({tag, "_idle_busy"}, FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, FULL_W'(cfg_if.cfg_done), FULL_W'(0));
        check({tag, "_done_count"}, FULL_W'(n_done - d0), FULL_W'(1));
    endtask

    initial begin
        logic [FULL_W-1:0] img_a;
        int                d0;
        n_assert = 0;
        n_fail   = 0;
        n_done   = 0;
        in_load  = 1'b0;
        rst      = 1'b1;
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_abort = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
`ifdef DICE_CFG_PARITY_EN
        cfg_if.cfg_parity = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_tile_cfg", cfg_if.tile_cfg, '0);
        check("rst_ready", FULL_W'(cfg_if.cfg_ready), FULL_W'(0));
        check("rst_busy", FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        check("rst_done", FULL_W'(cfg_if.cfg_done), FULL_W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frame, then hand-computed slices.
        run_frame(32'h1000_0000, 0, "f1");
        check("f1_t0_w0", FULL_W'(cfg_if.tile_cfg[31:0]), FULL_W'(32'h1000_0000));
        check("f1_t1_w0", FULL_W'(cfg_if.tile_cfg[156 +: 32]), FULL_W'(32'h1000_0005));
        check("f1_t0_w4", FULL_W'(cfg_if.tile_cfg[128 +: 28]), FULL_W'(28'h0000004));
        check("f1_t3_w4", FULL_W'(cfg_if.tile_cfg[3*156+128 +: 28]), FULL_W'(28'h0000013));

        // Same frame with random valid gaps.
        run_frame(32'h1000_0000, 40, "f2");
        img_a = cfg_if.tile_cfg;

        // Abort after 7 words of frame B; the abort cycle also presents a valid word.
        d0 = n_done;
        start_frame();
        for (int k = 0; k < 7; k++) send_word(32'hB000_0000 + 32'(k), 1'b0, 0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 32'hB000_0007;
`ifdef DICE_CFG_PARITY_EN
        cfg_if.cfg_parity = ^cfg_if.cfg_data;
`endif
        cfg_if.cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_if.cfg_abort = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        in_load = 1'b0;
        check("abort_busy", FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        repeat (3) @(posedge clk);
        #1;
        check("abort_tile_cfg", cfg_if.tile_cfg, img_a);
        check("abort_no_done", FULL_W'(n_done - d0), FULL_W'(0));

        // Frame C with cfg_start pulsed during LOAD and during COMMIT.
        d0 = n_done;
        start_frame();
        for (int k = 0; k < NWORDS; k++) begin
            cfg_if.cfg_start = (k == 3 || k == 11);
            send_word(32'hC000_0000 + 32'(k), 1'b0, 0);
        end
        cfg_if.cfg_start = 1'b1;
        in_load = 1'b0;
        @(posedge clk); #1;
        cfg_if.cfg_start = 1'b0;
        check("startc_done", FULL_W'(cfg_if.cfg_done), FULL_W'(1));
        check("startc_tile_cfg", cfg_if.tile_cfg, frame_img(32'hC000_0000));
        check("startc_busy", FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        repeat (2) @(posedge clk);
        #1;
        check("startc_busy_later", FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        check("startc_done_count", FULL_W'(n_done - d0), FULL_W'(1));

        // Reset at word 12 of frame D, then a fresh frame E.
        start_frame();
        for (int k = 0; k < 12; k++) send_word(32'hD000_0000 + 32'(k), 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_load = 1'b0;
        check("rst_mid_tile_cfg", cfg_if.tile_cfg, '0);
        check("rst_mid_busy", FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        check("rst_mid_ready", FULL_W'(cfg_if.cfg_ready), FULL_W'(0));
        @(posedge clk); #1;
        run_frame(32'hE000_0000, 20, "fe");

`ifdef DICE_CFG_PARITY_EN
        d0 = n_done;
        start_frame();
        for (int k = 0; k < 4; k++) send_word(32'hF000_0000 + 32'(k), (k == 3), 0);
        in_load = 1'b0;
        check("par_err", FULL_W'(cfg_if.cfg_err), FULL_W'(1));
        check("par_busy", FULL_W'(cfg_if.cfg_busy), FULL_W'(0));
        repeat (3) @(posedge clk);
        #1;
        check("par_tile_cfg", cfg_if.tile_cfg, frame_img(32'hE000_0000));
        check("par_no_done", FULL_W'(n_done - d0), FULL_W'(0));
        check("par_err_sticky", FULL_W'(cfg_if.cfg_err), FULL_W'(1));
        start_frame();
        check("par_err_clear", FULL_W'(cfg_if.cfg_err), FULL_W'(0));
        cfg_if.cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_if.cfg_abort = 1'b0;
        in_load = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
